compressor_tree_acc: RTL and testbench
======================================

Name: compressor_tree_acc

Overview:
- Pipelined four-operand adder built from a row of 5:3 compressor cells, followed by a registered carry-propagate stage and an optional accumulator.
- Successor of the single-bit 5:3 compressor: generalised to N bits, with handshaking, pipelining and an accumulate mode.
- Sits in the datapath as the reduction/accumulate unit for multiplier partial products and dot-product sums.

Parameters:
- N, 32, operand width in bits (N >= 2).
- ACC_EXT, 8, guard bits added above the N+2-bit sum in the accumulator.
- W, N+2+ACC_EXT, derived result/accumulator width; not overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a, b, c, d  in  N each  unsigned operands.
- mode  in  1  0 = plain sum, 1 = accumulate; travels with the beat.
- acc_clr  in  1  accumulate beats only: treat accumulator as 0 before adding; travels with the beat.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  W  result.
- overflow  out  1  accumulate wrap flag for this beat.

Behaviour:
- Reset (already decided): one clock; reset is synchronous and active-low.
- On a rising edge with rst_n=0:
  - s1_valid, s2_valid, out_valid = 0.
  - Accumulator = 0; sum = 0; overflow = 0.
  - Any in-flight beats are discarded; none reappear after reset.
- in_ready is combinational, so it is 1 in the first cycle after reset.
- Transfer rules: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
- Stage 1 (compressor row), registered on input transfer:
  - Bit i uses 5:3 semantics on inputs a[i], b[i], c[i], d[i], with Cin = intCout[i-1] and Cin = 0 at bit 0.
  - Outputs per bit: S[i] at weight 2^i; Cout[i] and intCout[i] at weight 2^(i+1).
  - intCout[i] depends only on a..d of bit i, so there is no ripple across bits.
  - Registered vectors:
    - sv (N+2 bits) = S.
    - cv (N+2 bits) = (Cout << 1) + (intCout[N-1] << N).
    - Invariant: sv + cv == a + b + c + d exactly.
  - mode and acc_clr are registered alongside the vectors.
- Stage 2 (CPA and accumulate), registered when stage 1 advances:
  - r = sv + cv, which is N+2 bits and cannot overflow.
  - mode = 0: sum = zero-extended r; overflow = 0; accumulator unchanged.
  - mode = 1: base = acc_clr ? 0 : acc; t = base + r computed at W+1 bits.
    - sum = t[W-1:0]; overflow = t[W]; acc <= t[W-1:0].
    - Wrap is modulo 2^W.
  - The accumulator updates when stage 2 loads, not on output transfer.
- Flow control:
  - s2 advances (output transfer) when out_ready.
  - s1 advances into s2 when s1_valid & (~s2_valid | out_ready).
  - in_ready = ~s1_valid | s1 advances.
- Latency and capacity:
  - Latency is 2 cycles from input transfer to out_valid with no stall.
  - Throughput is 1 beat/cycle.
  - Capacity is 2 beats.
  - Beat order is preserved; no beat is dropped or duplicated.
- Stability: while out_valid & ~out_ready, sum and overflow are held stable.
- Simultaneous events:
  - Input and output transfers in the same cycle with both stages full proceed without a bubble.
  - Accumulate beats in consecutive cycles chain correctly; stage 2 uses the acc value written by the previous beat.
- Reset asserted mid-operation overrides all transfers in that cycle.

Test Plan:
- N=32, ACC_EXT=8, mode=0, a=b=c=d=0xFFFFFFFF -> sum=0x3_FFFF_FFFC, overflow=0, out_valid exactly 2 cycles after acceptance.
- N=4, mode=0: exhaustive sweep of all 65536 a..d combos, back-to-back beats -> sum = a+b+c+d for every beat, in order; compare against a behavioural adder.
- Backpressure:
  - Stimulus: out_ready=0, in_valid held for 4 beats (values 1..4 in each operand).
  - Response: 2 beats accepted, in_ready=0 from the next cycle, and sum holds 4.
  - Raising out_ready delivers 4, 8, 12, 16 in order with no loss.
- Accumulate:
  - mode=1, acc_clr=1, operands 1,2,3,4 -> sum=10.
  - Next beat mode=1, acc_clr=0, operands 10,10,10,10 -> sum=50.
  - Next beat mode=0, operands 1,1,1,1 -> sum=4, with the accumulator still 50.
- Overflow with N=4, ACC_EXT=0 (W=6):
  - Accumulate beats: 15,15,15,15 with clr (sum=60), then 15,15,15,15 (sum=56, overflow=1).
  - Next beat 0,0,0,1 (sum=57, overflow=0).
- Reset mid-stream:
  - Stimulus: rst_n=0 for 1 cycle with both stages full.
  - Response: out_valid=0, sum=0, overflow=0 next cycle, in_ready=1.
  - A subsequent accumulate beat without clr, operands 1,0,0,0 -> sum=1.

Source files
------------

// File: rtl/compressor_tree_acc_if.sv
// compressor_tree_acc_if
// Bundles the input beat handshake and the result beat handshake of
// compressor_tree_acc so both ends share one set of widths.
// Signals:
//   in_valid / in_ready    - input beat handshake
//   a, b, c, d             - N-bit unsigned operands
//   mode                   - 0 = plain sum, 1 = accumulate
//   acc_clr                - accumulate beats only: start from zero
//   out_valid / out_ready  - result beat handshake
//   sum                    - W-bit result, W = N + 2 + ACC_EXT
//   overflow               - accumulator wrapped on this beat
// Modports:
//   master - the side that produces operands and consumes results
//   slave  - the compressor/accumulator itself
interface compressor_tree_acc_if #(
   parameter int N       = 32,
   parameter int ACC_EXT = 8
);
   localparam int W = N + 2 + ACC_EXT;

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] c;
   logic [N-1:0] d;
   logic         mode;
   logic         acc_clr;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         overflow;

   modport master (
      output in_valid, a, b, c, d, mode, acc_clr, out_ready,
      input  in_ready, out_valid, sum, overflow
   );

   modport slave (
      input  in_valid, a, b, c, d, mode, acc_clr, out_ready,
      output in_ready, out_valid, sum, overflow
   );
endinterface

// File: rtl/compressor_tree_acc.sv
// compressor_tree_acc
// Pipelined four-operand adder with optional accumulation.
// Stage 1 is a row of 5:3 compressor cells that reduces a, b, c, d to a
// sum vector and a carry vector without any carry ripple across bits.
// Stage 2 merges the two vectors with a carry-propagate add and either
// returns the plain sum or adds it into a W-bit wrapping accumulator.
// Ports:
//   clk    - single clock, all state changes on the rising edge
//   rst_n  - synchronous active-low reset; empties both stages, clears
//            the accumulator and the result registers
//   bus    - slave side of compressor_tree_acc_if (operand beat in,
//            result beat out, valid/ready on both sides)
module compressor_tree_acc #(
   parameter int N       = 32,
   parameter int ACC_EXT = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   compressor_tree_acc_if.slave bus
);
   localparam int W = N + 2 + ACC_EXT;
   localparam int R = N + 2;

   logic [N-1:0] firstSum;
   logic [N-1:0] intCout;
   logic [N-1:0] rowCin;
   logic [N-1:0] rowSum;
   logic [N-1:0] rowCout;
   logic [R-1:0] svNext;
   logic [R-1:0] cvNext;

   logic         s1Valid;
   logic         s1Mode;
   logic         s1Clr;
   logic [R-1:0] s1Sv;
   logic [R-1:0] s1Cv;

   logic         s2Valid;
   logic [W-1:0] sumReg;
   logic         overflowReg;
   logic [W-1:0] acc;

   logic         s1Advance;
   logic         inReady;
   logic         inXfer;
   logic [R-1:0] cpaSum;
   logic [W-1:0] accBase;
   logic [W:0]   accSum;

   // Compressor row. Each cell is two chained full adders: the first adds
   // a, b, c and hands its carry (intCout) to the next bit up, the second
   // adds that partial sum to d and the carry arriving from the bit below.
   // Because intCout only looks at a, b, c of its own bit, no carry travels
   // more than one position. The top intCout has no cell above it, so it is
   // folded into the carry vector at weight 2^N.
   always_comb begin
      firstSum = bus.a ^ bus.b ^ bus.c;
      intCout  = (bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c);
      rowCin   = {intCout[N-2:0], 1'b0};
      rowSum   = firstSum ^ bus.d ^ rowCin;
      rowCout  = (firstSum & bus.d) | (firstSum & rowCin) | (bus.d & rowCin);
      svNext   = {2'b00, rowSum};
      cvNext   = {1'b0, rowCout, 1'b0} + {1'b0, intCout[N-1], {N{1'b0}}};
   end

   // Flow control. Stage 1 may move into stage 2 when stage 2 is empty or
   // is handing its beat downstream this cycle; a new beat may enter when
   // stage 1 is empty or is moving on, which lets a full pipe accept and
   // deliver in the same cycle without a bubble.
   always_comb begin
      s1Advance = s1Valid & (~s2Valid | bus.out_ready);
      inReady   = ~s1Valid | s1Advance;
      inXfer    = bus.in_valid & inReady;
   end

   // Carry-propagate add plus accumulate. The vectors from stage 1 always
   // fit in N+2 bits. The accumulate add is one bit wider than the
   // accumulator so the bit lost on wrap-around becomes the overflow flag.
   always_comb begin
      cpaSum  = s1Sv + s1Cv;
      accBase = s1Clr ? '0 : acc;
      accSum  = (W+1)'(accBase) + (W+1)'(cpaSum);
   end

   // Pipeline registers. The accumulator is written when a beat enters
   // stage 2, so back-to-back accumulate beats each see the value left by
   // the one before. While a result waits for out_ready, stage 2 does not
   // load, which keeps sum and overflow steady.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1Valid     <= 1'b0;
         s1Mode      <= 1'b0;
         s1Clr       <= 1'b0;
         s1Sv        <= '0;
         s1Cv        <= '0;
         s2Valid     <= 1'b0;
         sumReg      <= '0;
         overflowReg <= 1'b0;
         acc         <= '0;
      end else begin
         if (inXfer) begin
            s1Valid <= 1'b1;
            s1Mode  <= bus.mode;
            s1Clr   <= bus.acc_clr;
            s1Sv    <= svNext;
            s1Cv    <= cvNext;
         end else if (s1Advance) begin
            s1Valid <= 1'b0;
         end

         if (s1Advance) begin
            s2Valid <= 1'b1;
            if (s1Mode) begin
               sumReg      <= accSum[W-1:0];
               overflowReg <= accSum[W];
               acc         <= accSum[W-1:0];
            end else begin
               sumReg      <= W'(cpaSum);
               overflowReg <= 1'b0;
            end
         end else if (bus.out_ready) begin
            s2Valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = s2Valid;
   assign bus.sum       = sumReg;
   assign bus.overflow  = overflowReg;
endmodule

// File: tb/tb_compressor_tree_acc.sv
// tb_compressor_tree_acc
// Drives two instances: a 32-bit one with 8 guard bits and a 4-bit one
// with no guard bits (6-bit accumulator, so wrap-around is easy to reach).
// Expected results come from hand-written tables and from a reference
// model that keeps the accumulator as a plain integer and computes each
// result from the beat's operands with ordinary arithmetic.
module tb_compressor_tree_acc;
   typedef struct {
      logic [63:0] sum;
      logic        ov;
   } expT;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
      logic        mode;
      logic        clr;
      logic [63:0] expSum;
      logic        expOv;
   } vecT;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   compressor_tree_acc_if #(.N(32), .ACC_EXT(8)) busA ();
   compressor_tree_acc_if #(.N(4),  .ACC_EXT(0)) busB ();

   compressor_tree_acc #(.N(32), .ACC_EXT(8)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
   compressor_tree_acc #(.N(4),  .ACC_EXT(0)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

   int checks = 0;
   int errors = 0;
   expT qA[$];
   expT qB[$];
   longint unsigned accA = 0;
   longint unsigned accB = 0;

   // One comparison: bumps the counters and reports any difference.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
      end
   endtask

   // Reference model: result of one accepted beat, in beat order.
   task automatic modelStep(input bit useB, input logic [31:0] va, vb, vc, vd,
                            input logic md, cl, output expT e);
      longint unsigned r, base, t, mask;
      logic [31:0] opMask;
      int w;
      opMask = useB ? 32'h0000_000F : 32'hFFFF_FFFF;
      w      = useB ? 6 : 42;
      mask   = (64'd1 << w) - 64'd1;
      r      = 64'(va & opMask) + 64'(vb & opMask) + 64'(vc & opMask) + 64'(vd & opMask);
      base   = useB ? accB : accA;
      if (cl) base = 0;
      if (!md) begin
         e.sum = r;
         e.ov  = 1'b0;
      end else begin
         t     = base + r;
         e.sum = t & mask;
         e.ov  = ((t >> w) & 64'd1) != 0;
         if (useB) accB = t & mask;
         else accA = t & mask;
      end
   endtask

   // One clock cycle on the chosen instance: drive at the falling edge,
   // sample 1 time unit later, check any result handed over this cycle.
   task automatic applyStimulus(input bit useB, input logic iv, input logic [31:0] va, vb, vc, vd,
                                input logic md, cl, input logic ordy, output bit accepted);
      logic        outV, inR;
      logic [63:0] outSum, outOv;
      expT         e;
      @(negedge clk);
      if (useB) begin
         busB.in_valid  = iv;
         busB.a         = va[3:0];
         busB.b         = vb[3:0];
         busB.c         = vc[3:0];
         busB.d         = vd[3:0];
         busB.mode      = md;
         busB.acc_clr   = cl;
         busB.out_ready = ordy;
         busA.in_valid  = 1'b0;
      end else begin
         busA.in_valid  = iv;
         busA.a         = va;
         busA.b         = vb;
         busA.c         = vc;
         busA.d         = vd;
         busA.mode      = md;
         busA.acc_clr   = cl;
         busA.out_ready = ordy;
         busB.in_valid  = 1'b0;
      end
      #1;
      if (useB) begin
         inR    = busB.in_ready;
         outV   = busB.out_valid;
         outSum = 64'(busB.sum);
         outOv  = 64'(busB.overflow);
      end else begin
         inR    = busA.in_ready;
         outV   = busA.out_valid;
         outSum = 64'(busA.sum);
         outOv  = 64'(busA.overflow);
      end
      accepted = iv & inR;
      if (outV & ordy) begin
         if ((useB ? qB.size() : qA.size()) == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected beat: actual sum 0x%0h required no beat", outSum);
         end else begin
            if (useB) e = qB.pop_front();
            else e = qA.pop_front();
            checkOutput(useB ? "sumB" : "sumA", outSum, e.sum);
            checkOutput(useB ? "overflowB" : "overflowA", outOv, 64'(e.ov));
         end
      end
   endtask

   // Offer one beat until accepted (bounded), then queue its expectation.
   task automatic sendBeat(input bit useB, input logic [31:0] va, vb, vc, vd, input logic md, cl,
                           input bit randReady, input bit useTable, input logic [63:0] tSum, input logic tOv);
      bit  accepted;
      int  tries;
      expT e;
      accepted = 1'b0;
      tries    = 0;
      while (!accepted && tries < 50) begin
         applyStimulus(useB, 1'b1, va, vb, vc, vd, md, cl,
                       randReady ? 1'($urandom_range(0, 3) != 0) : 1'b1, accepted);
         tries++;
      end
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept timeout: actual not accepted in %0d cycles required accept", tries);
      end else begin
         modelStep(useB, va, vb, vc, vd, md, cl, e);
         if (useTable) begin
            e.sum = tSum;
            e.ov  = tOv;
         end
         if (useB) qB.push_back(e);
         else qA.push_back(e);
      end
   endtask

   // Let outstanding results flow out, bounded, then watch two idle cycles.
   task automatic drain(input bit useB);
      bit dummy;
      int cnt;
      cnt = 0;
      while ((useB ? qB.size() : qA.size()) != 0 && cnt < 20) begin
         applyStimulus(useB, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, dummy);
         cnt++;
      end
      if ((useB ? qB.size() : qA.size()) != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain timeout: actual %0d beats pending required 0",
                  useB ? qB.size() : qA.size());
      end
      repeat (2) applyStimulus(useB, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, dummy);
   endtask

   initial begin
      vecT tabA[10];
      vecT tabB[6];
      bit  acc;
      int  k;
      int  guard;
      int  latency;
      expT e;

      tabA[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'h3_FFFF_FFFC, 1'b0};
      tabA[1] = '{32'd1, 32'd2, 32'd3, 32'd4, 1'b1, 1'b1, 64'd10, 1'b0};
      tabA[2] = '{32'd10, 32'd10, 32'd10, 32'd10, 1'b1, 1'b0, 64'd50, 1'b0};
      tabA[3] = '{32'd1, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0, 64'd4, 1'b0};
      tabA[4] = '{32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 64'd50, 1'b0};
      tabA[5] = '{32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 64'h1_FFFF_FFFF, 1'b0};
      tabA[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h3_FFFF_FFFC, 1'b0};
      tabA[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'h7_FFFF_FFF8, 1'b0};
      tabA[8] = '{32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0};
      tabA[9] = '{32'h8000_0000, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 64'h8_7FFF_FFF8, 1'b0};

      tabB[0] = '{32'd15, 32'd15, 32'd15, 32'd15, 1'b1, 1'b1, 64'd60, 1'b0};
      tabB[1] = '{32'd15, 32'd15, 32'd15, 32'd15, 1'b1, 1'b0, 64'd56, 1'b1};
      tabB[2] = '{32'd0, 32'd0, 32'd0, 32'd1, 1'b1, 1'b0, 64'd57, 1'b0};
      tabB[3] = '{32'd15, 32'd15, 32'd15, 32'd15, 1'b0, 1'b0, 64'd60, 1'b0};
      tabB[4] = '{32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 64'd57, 1'b0};
      tabB[5] = '{32'd7, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 64'd0, 1'b1};

      rst_n = 1'b0;
      busA.in_valid = 1'b0; busA.a = '0; busA.b = '0; busA.c = '0; busA.d = '0;
      busA.mode = 1'b0; busA.acc_clr = 1'b0; busA.out_ready = 1'b0;
      busB.in_valid = 1'b0; busB.a = '0; busB.b = '0; busB.c = '0; busB.d = '0;
      busB.mode = 1'b0; busB.acc_clr = 1'b0; busB.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("reset out_valid A", 64'(busA.out_valid), 64'd0);
      checkOutput("reset sum A", 64'(busA.sum), 64'd0);
      checkOutput("reset overflow A", 64'(busA.overflow), 64'd0);
      checkOutput("reset in_ready A", 64'(busA.in_ready), 64'd1);
      checkOutput("reset out_valid B", 64'(busB.out_valid), 64'd0);
      checkOutput("reset sum B", 64'(busB.sum), 64'd0);
      checkOutput("reset overflow B", 64'(busB.overflow), 64'd0);
      checkOutput("reset in_ready B", 64'(busB.in_ready), 64'd1);

      // Back-to-back table beats, including chained accumulates.
      for (int i = 0; i < 10; i++)
         sendBeat(1'b0, tabA[i].a, tabA[i].b, tabA[i].c, tabA[i].d, tabA[i].mode, tabA[i].clr,
                  1'b0, 1'b1, tabA[i].expSum, tabA[i].expOv);
      drain(1'b0);
      for (int i = 0; i < 6; i++)
         sendBeat(1'b1, tabB[i].a, tabB[i].b, tabB[i].c, tabB[i].d, tabB[i].mode, tabB[i].clr,
                  1'b0, 1'b1, tabB[i].expSum, tabB[i].expOv);
      drain(1'b1);

      // Latency from acceptance to result with no stall.
      sendBeat(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,
               1'b0, 1'b1, 64'h3_FFFF_FFFC, 1'b0);
      latency = 0;
      while (qA.size() != 0 && latency < 10) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
         latency++;
      end
      checkOutput("latency", 64'(latency), 64'd2);
      drain(1'b0);

      // Backpressure: two beats fill the pipe, then it stalls holding sum 4.
      k = 1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         applyStimulus(1'b0, 1'b1, 32'(k), 32'(k), 32'(k), 32'(k), 1'b0, 1'b0, 1'b0, acc);
         if (acc) begin
            e.sum = 64'(4 * k);
            e.ov  = 1'b0;
            qA.push_back(e);
            k++;
         end
         if (cyc >= 2) begin
            checkOutput("stall in_ready", 64'(busA.in_ready), 64'd0);
            checkOutput("stall out_valid", 64'(busA.out_valid), 64'd1);
            checkOutput("stall sum hold", 64'(busA.sum), 64'd4);
         end
      end
      checkOutput("stall accepted beats", 64'(k - 1), 64'd2);
      guard = 0;
      while (k <= 4 && guard < 50) begin
         applyStimulus(1'b0, 1'b1, 32'(k), 32'(k), 32'(k), 32'(k), 1'b0, 1'b0, 1'b1, acc);
         if (acc) begin
            e.sum = 64'(4 * k);
            e.ov  = 1'b0;
            qA.push_back(e);
            k++;
         end
         guard++;
      end
      drain(1'b0);

      // Reset with both stages full; the stored beats must vanish.
      applyStimulus(1'b0, 1'b1, 32'd5, 32'd5, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, acc);
      applyStimulus(1'b0, 1'b1, 32'd6, 32'd6, 32'd6, 32'd6, 1'b0, 1'b0, 1'b0, acc);
      @(negedge clk);
      rst_n = 1'b0;
      busA.in_valid = 1'b1; busA.a = 32'd7; busA.b = 32'd7; busA.c = 32'd7; busA.d = 32'd7;
      busA.mode = 1'b1; busA.acc_clr = 1'b0; busA.out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      busA.in_valid = 1'b0;
      busA.out_ready = 1'b0;
      #1;
      checkOutput("midreset out_valid", 64'(busA.out_valid), 64'd0);
      checkOutput("midreset sum", 64'(busA.sum), 64'd0);
      checkOutput("midreset overflow", 64'(busA.overflow), 64'd0);
      checkOutput("midreset in_ready", 64'(busA.in_ready), 64'd1);
      qA.delete();
      accA = 0;
      accB = 0;
      sendBeat(1'b0, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 64'd1, 1'b0);
      drain(1'b0);

      // Every 4-bit operand combination, back to back, plain sum.
      for (int i = 0; i < 65536; i++) begin
         logic [15:0] v;
         v = 16'(i);
         sendBeat(1'b1, 32'(v[3:0]), 32'(v[7:4]), 32'(v[11:8]), 32'(v[15:12]), 1'b0, 1'b0,
                  1'b0, 1'b0, 64'd0, 1'b0);
      end
      drain(1'b1);

      // Random traffic with random stalls and idle cycles.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 3) == 0)
            applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0,
                          1'($urandom_range(0, 1)), acc);
         else
            sendBeat(1'b1, 32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)),
                     32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                     1'b1, 1'b0, 64'd0, 1'b0);
      end
      drain(1'b1);
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 3) == 0)
            applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0,
                          1'($urandom_range(0, 1)), acc);
         else
            sendBeat(1'b0, 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                     1'b1, 1'b0, 64'd0, 1'b0);
      end
      drain(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
